// File: rtl/ps2_rx_frame_if.sv
`default_nettype none
// ============================================================================
// ps2_rx_frame_if : PS/2 pins, receive enable and decoded-frame outputs
// Rev 1.0
// ============================================================================
interface ps2_rx_frame_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       bit_pari_tecla;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  modport master (
    output ps2c, ps2d, rx_en,
    input  rx_done_tick, dout, bit_pari_tecla, parity_err, frame_err, timeout_tick
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output rx_done_tick, dout, bit_pari_tecla, parity_err, frame_err, timeout_tick
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// ps2_rx_frame : filtered PS/2 receiver delivering byte, parity and error flags
// Rev 1.0
// ============================================================================
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  wire logic     reloj,
  input  wire logic     reset,
  ps2_rx_frame_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DPS  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]            c_sync_q;
  logic [1:0]            d_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q;
  logic                  filt_q;
  logic                  filt_d;
  logic                  fall_edge;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [TO_W-1:0]       wd_q;
  logic [9:0]            sr_q;
  logic [7:0]            dout_q;
  logic                  par_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  done_q;
  logic                  to_q;

  // Filtered level only moves when the whole window agrees; otherwise it holds.
  always_comb begin
    filt_d = filt_q;
    if (&filt_sr_q)
      filt_d = 1'b1;
    else if (~|filt_sr_q)
      filt_d = 1'b0;
  end

  assign fall_edge = filt_q & ~filt_d;

  always_ff @(posedge reloj) begin
    if (reset) begin
      c_sync_q  <= '1;
      d_sync_q  <= '1;
      filt_sr_q <= '1;
      filt_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      sr_q      <= '0;
      dout_q    <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      c_sync_q  <= {c_sync_q[0], bus.ps2c};
      d_sync_q  <= {d_sync_q[0], bus.ps2d};
      filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], c_sync_q[1]};
      filt_q    <= filt_d;
      done_q    <= 1'b0;
      to_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (fall_edge && bus.rx_en && !d_sync_q[1]) begin
            state_q <= S_DPS;
            cnt_q   <= 4'd9;
          end
        end
        S_DPS: begin
          if (fall_edge) begin
            sr_q <= {d_sync_q[1], sr_q[9:1]};
            wd_q <= '0;
            if (cnt_q == 4'd0)
              state_q <= S_LOAD;
            else
              cnt_q <= cnt_q - 4'd1;
          end else if (wd_q == c_to_last) begin
            // Stalled frame: abandon it without touching the delivered outputs.
            state_q <= S_IDLE;
            to_q    <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_IDLE;
          dout_q  <= sr_q[7:0];
          par_q   <= sr_q[8];
          perr_q  <= ~(^sr_q[8:0]);
          ferr_q  <= ~sr_q[9];
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_done_tick   = done_q;
  assign bus.dout           = dout_q;
  assign bus.bit_pari_tecla = par_q;
  assign bus.parity_err     = perr_q;
  assign bus.frame_err      = ferr_q;
  assign bus.timeout_tick   = to_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// tb_ps2_rx_frame : scoreboard bench for ps2_rx_frame
// Rev 1.0
// ============================================================================
module tb_ps2_rx_frame;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int TO_W        = 11;
  localparam int HALF        = 50;
  // Drive-to-tick latency: 2 sync + FILTER_LEN filter + 2 (dps->load->tick), +/-1.
  localparam int LAT_NOM     = FILTER_LEN + 4;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic reloj = 1'b0;
  logic reset = 1'b1;
  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_tick = 0;
  int   n_to = 0;
  int   cyc = 0;
  int   stop_cyc = 0;

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  always @(negedge reloj) begin
    exp_t e;
    int   lat;
    if (!reset) begin
      if (bus.rx_done_tick) begin
        n_tick++;
        if (sb_q.size() == 0) begin
          check("unexpected_tick", 32'd1, 32'd0);
        end else begin
          e   = sb_q.pop_front();
          lat = cyc - stop_cyc;
          check("dout", {24'd0, bus.dout}, {24'd0, e.data});
          check("parity_bit", {31'd0, bus.bit_pari_tecla}, {31'd0, e.par});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
          check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.ferr});
          check("latency_window", {31'd0, (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1)}, 32'd1);
        end
      end
      if (bus.timeout_tick) n_to++;
    end
  end

  // Sends start + the first nbits of {stop, par, data}; pushes an expectation if a tick is due.
  task automatic send(input logic [7:0] data, input logic par, input logic stop,
                      input int nbits, input bit expect_tick, input bit drop_en);
    logic [10:0] bits;
    exp_t        e;
    bits = {stop, par, data, 1'b0};
    if (expect_tick) begin
      e.data = data;
      e.par  = par;
      e.perr = (par != ~(^data));
      e.ferr = ~stop;
      sb_q.push_back(e);
    end
    for (int i = 0; i <= nbits; i++) begin
      bus.ps2d = bits[i];
      repeat (HALF) @(negedge reloj);
      bus.ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge reloj);
      bus.ps2c = 1'b1;
      if (i == 0 && drop_en) bus.rx_en = 1'b0;
    end
    bus.ps2d = 1'b1;
    repeat (HALF) @(negedge reloj);
  endtask

  initial begin
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge reloj);
    check("rst_dout", {24'd0, bus.dout}, 32'd0);
    check("rst_par", {31'd0, bus.bit_pari_tecla}, 32'd0);
    check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("rst_tick", {31'd0, bus.rx_done_tick}, 32'd0);
    check("rst_to", {31'd0, bus.timeout_tick}, 32'd0);
    reset = 1'b0;

    repeat (1000) @(negedge reloj);
    check("idle_ticks", n_tick, 0);
    check("idle_timeouts", n_to, 0);

    send(8'h1C, 1'b0, 1'b1, 10, 1'b1, 1'b0);
    check("first_frame_ticks", n_tick, 1);

    send(8'hF0, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b1, 10, 1'b1, 1'b0);
    repeat (200) @(negedge reloj);
    check("b2b_hold_dout", {24'd0, bus.dout}, 32'h1C);
    check("b2b_ticks", n_tick, 3);

    send(8'h1C, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 10, 1'b1, 1'b0);

    // Start plus four data bits, then the bus stalls high.
    send(8'hA5, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    repeat (2100) @(negedge reloj);
    check("timeout_count", n_to, 1);
    check("timeout_no_tick", n_tick, 5);
    check("timeout_dout_held", {24'd0, bus.dout}, 32'h1C);
    check("timeout_ferr_held", {31'd0, bus.frame_err}, 32'd1);
    check("timeout_perr_held", {31'd0, bus.parity_err}, 32'd0);

    send(8'h1C, 1'b0, 1'b1, 10, 1'b1, 1'b0);

    repeat (4) begin
      bus.ps2c = 1'b0;
      repeat (5) @(negedge reloj);
      bus.ps2c = 1'b1;
      repeat (30) @(negedge reloj);
    end
    check("glitch_ticks", n_tick, 6);

    bus.rx_en = 1'b0;
    send(8'h1C, 1'b0, 1'b1, 10, 1'b0, 1'b0);
    check("rx_en_off_ticks", n_tick, 6);
    bus.rx_en = 1'b1;

    send(8'h1C, 1'b0, 1'b1, 10, 1'b1, 1'b1);
    bus.rx_en = 1'b1;
    repeat (200) @(negedge reloj);

    check("final_ticks", n_tick, 7);
    check("final_timeouts", n_to, 1);
    check("scoreboard_empty", sb_q.size(), 0);
    check("final_dout", {24'd0, bus.dout}, 32'h1C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
